obi_to_wb: RTL and testbench

- OBI slave port to Wishbone B4 classic master bridge; the reverse direction of the team's Wishbone-to-OBI adapter.
- An OBI master (core LSU or fetch unit) drives this block, which runs one Wishbone cycle per accepted OBI request and returns exactly one OBI response per request.
- Single clock domain; only one transaction is outstanding at a time.
- A bus-hang timeout converts an unresponsive Wishbone slave into an OBI error response.

---
 rtl/obi_to_wb.sv | 113 +++++++++++
 tb/tb_obi_to_wb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_to_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obi_to_wb : OBI slave to Wishbone B4 classic master, one transfer in flight |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module obi_to_wb #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        wb_rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   localparam logic [1:0]  c_IDLE    = 2'd0;
   localparam logic [1:0]  c_BUS     = 2'd1;
   localparam logic [1:0]  c_RESP    = 2'd2;
   localparam logic        c_TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic [15:0] r_cnt;
   logic        r_err;
   logic [31:0] r_rdata;
   logic        r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_adr;
   logic [31:0] r_dat;

   logic w_grant;
   logic w_done;
   logic w_timeout;

   // Reset gates the grant so no request is accepted while held in reset
   assign w_grant   = (r_state == c_IDLE) && req_i && !wb_rst_i;
   assign w_done    = wbm_ack_i | wbm_err_i;
   assign w_timeout = c_TO_EN && !w_done && (r_cnt == c_TO_LAST);

   always_ff @(posedge clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= c_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_adr   <= '0;
         r_dat   <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_grant) begin
                  r_we    <= we_i;
                  r_sel   <= be_i;
                  r_adr   <= addr_i;
                  r_dat   <= wdata_i;
                  r_cnt   <= '0;
                  r_state <= c_BUS;
               end
            end
            c_BUS: begin
               if (w_done) begin
                  // Error dominates a simultaneous ack and never returns data
                  r_err   <= wbm_err_i;
                  r_rdata <= (!r_we && !wbm_err_i) ? wbm_dat_i : 32'h0;
                  r_state <= c_RESP;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= 32'h0;
                  r_state <= c_RESP;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            c_RESP: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign gnt_o     = w_grant;
   assign rvalid_o  = (r_state == c_RESP);
   assign rdata_o   = rvalid_o ? r_rdata : 32'h0;
   assign err_o     = rvalid_o & r_err;
   assign wbm_cyc_o = (r_state == c_BUS);
   assign wbm_stb_o = (r_state == c_BUS);
   assign wbm_we_o  = r_we;
   assign wbm_sel_o = r_sel;
   assign wbm_adr_o = r_adr;
   assign wbm_dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_obi_to_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_obi_to_wb : randomized self-checking bench for obi_to_wb                |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_obi_to_wb;

   localparam int unsigned c_TO = 8;
   localparam int c_ACK  = 0;
   localparam int c_ERR  = 1;
   localparam int c_BOTH = 2;
   localparam int c_NONE = 3;

   logic        clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        gnt_o;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = '0;
   logic [31:0] wdata_i = '0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_err_i = 1'b0;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   longint      cyc_cnt = 0;
   longint      last_gnt = 0;

   obi_to_wb #(.TIMEOUT_CYCLES(c_TO)) u_dut (
      .clk_i     (clk_i),
      .wb_rst_i  (wb_rst_i),
      .req_i     (req_i),
      .gnt_o     (gnt_o),
      .addr_i    (addr_i),
      .we_i      (we_i),
      .be_i      (be_i),
      .wdata_i   (wdata_i),
      .rvalid_o  (rvalid_o),
      .rdata_o   (rdata_o),
      .err_o     (err_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .wbm_err_i (wbm_err_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One OBI transaction against a scripted slave: kind selects ack/err/both/none,
   // waits is the number of wait states before the slave answers.
   task automatic do_txn(input logic we, input logic [31:0] adr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits,
                         input int kind, input bit hold, input int gap);
      int          stb_n;
      int          exp_stb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      exp_rdata = (kind == c_ACK && !we) ? rd : 32'h0;
      exp_err   = (kind != c_ACK);
      exp_stb   = (kind == c_NONE) ? int'(c_TO) : waits + 1;

      @(posedge clk_i); #1;
      req_i = 1'b1; we_i = we; addr_i = adr; be_i = be; wdata_i = wd;
      #1;
      check("idle_rvalid", 32'(rvalid_o), 0);
      check("idle_rdata", rdata_o, 0);
      check("idle_cyc", 32'(wbm_cyc_o), 0);
      check("gnt", 32'(gnt_o), 1);
      if (gap > 0) check("gnt_gap", 32'(cyc_cnt - last_gnt), 32'(gap));
      last_gnt = cyc_cnt;

      stb_n = 0;
      for (int t = 0; t < 40; t++) begin
         @(posedge clk_i); #1;
         wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
         if (!hold) begin
            req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom);
            we_i = 1'($urandom);
         end
         #1;
         if (!wbm_cyc_o) break;
         stb_n++;
         check("stb", 32'(wbm_stb_o), 1);
         check("bus_gnt", 32'(gnt_o), 0);
         check("bus_rvalid", 32'(rvalid_o), 0);
         check("wb_we", 32'(wbm_we_o), 32'(we));
         check("wb_sel", 32'(wbm_sel_o), 32'(be));
         check("wb_adr", wbm_adr_o, adr);
         check("wb_dat", wbm_dat_o, wd);
         if (kind != c_NONE && stb_n == waits + 1) begin
            wbm_ack_i = (kind != c_ERR);
            wbm_err_i = (kind != c_ACK);
            wbm_dat_i = rd;
         end
      end
      check("stb_cycles", 32'(stb_n), 32'(exp_stb));
      check("rvalid", 32'(rvalid_o), 1);
      check("rdata", rdata_o, exp_rdata);
      check("err", 32'(err_o), 32'(exp_err));
      check("resp_cyc", 32'(wbm_cyc_o | wbm_stb_o), 0);
      check("resp_gnt", 32'(gnt_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      req_i = 1'b1; #1;
      check("rst_gnt", 32'(gnt_o), 0);
      check("rst_rvalid", 32'(rvalid_o), 0);
      check("rst_outs", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, err_o}), 0);
      check("rst_sel", 32'(wbm_sel_o), 0);
      check("rst_adr", wbm_adr_o, 0);
      check("rst_dat", wbm_dat_o, 0);
      check("rst_rdata", rdata_o, 0);
      req_i = 1'b0;
      wb_rst_i = 1'b0;

      do_txn(1'b0, 32'h0000_1000, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, c_ACK, 1'b0, 0);
      do_txn(1'b1, 32'h0000_0020, 4'h3, 32'h1234_5678, 32'hFFFF_FFFF, 3, c_ACK, 1'b0, 0);
      do_txn(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'hCAFE_F00D, 1, c_BOTH, 1'b0, 0);

      // Timeout, then a stray late ack must be ignored
      do_txn(1'b0, 32'h0000_0080, 4'hF, 32'h0, 32'h5555_AAAA, 0, c_NONE, 1'b0, 0);
      @(posedge clk_i); #1;
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_0BAD; #1;
      check("late_cyc", 32'(wbm_cyc_o), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         wbm_ack_i = 1'b0; #1;
         check("late_rvalid", 32'(rvalid_o), 0);
         check("late_cyc2", 32'(wbm_cyc_o), 0);
      end

      // Back-to-back with req held high
      do_txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'h1111_1111, 0, c_ACK, 1'b1, 0);
      do_txn(1'b1, 32'h0000_0104, 4'hC, 32'h2222_2222, 32'h0, 0, c_ACK, 1'b1, 3);
      do_txn(1'b0, 32'h0000_0108, 4'h1, 32'h0, 32'h3333_3333, 0, c_ACK, 1'b1, 3);
      req_i = 1'b0;

      // Async reset while stb is high
      @(posedge clk_i); #1;
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0200; be_i = 4'hF;
      @(posedge clk_i); #1;
      #1;
      check("pre_rst_stb", 32'(wbm_stb_o), 1);
      #1;
      wb_rst_i = 1'b1; #1;
      check("arst_cyc", 32'(wbm_cyc_o), 0);
      check("arst_stb", 32'(wbm_stb_o), 0);
      check("arst_gnt", 32'(gnt_o), 0);
      check("arst_rvalid", 32'(rvalid_o), 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk_i); #1;
         check("arst_hold_rvalid", 32'(rvalid_o), 0);
      end
      req_i = 1'b0;
      wb_rst_i = 1'b0;
      @(posedge clk_i); #1;
      check("post_rst_rvalid", 32'(rvalid_o), 0);
      do_txn(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h7777_8888, 1, c_ACK, 1'b0, 0);

      // Randomized traffic
      for (int i = 0; i < 30; i++) begin
         int k;
         int kind;
         k = int'($urandom_range(0, 7));
         kind = (k <= 3 || k == 7) ? c_ACK : (k == 4) ? c_ERR : (k == 5) ? c_BOTH : c_NONE;
         do_txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 4)), kind, 1'b0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
